pci_arbiter: RTL and testbench

Central bus arbiter for the shared PCI-style bus: the responder side of each device controller's `req`/`gnt` pair. It samples up to NDEV active-low requests and watches `frame`/`irdy` to find bus-idle boundaries. It grants the bus round-robin with one-cycle turnaround gaps between owners, and parks the bus on a default device when nobody requests. It sits at top level beside the device controllers and drives one `gnt` line per device; device index equals `devaddress`.

---
 rtl/pci_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/pci_arbiter.sv | 156 +++++++++++++++
 tb/tb_pci_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// Shared definitions for the PCI bus arbiter and the device controllers:
// active-low polarity constants, arbiter state encodings and an index-width helper.
package pci_arb_pkg;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  localparam logic [1:0] ST_PARK    = 2'd0;
  localparam logic [1:0] ST_TURN    = 2'd1;
  localparam logic [1:0] ST_GRANTED = 2'd2;
  localparam logic [1:0] ST_BUSY    = 2'd3;

  function automatic int unsigned IDX_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first active request after i_ptr, wrapping,
// with i_ptr itself searched last or skipped entirely when i_excl is set.
module rr_pick
  import pci_arb_pkg::*;
#(
  parameter  int unsigned NDEV = 4,
  localparam int unsigned IW   = IDX_W(NDEV)
) (
  input  logic [NDEV-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_excl,
  output logic            o_valid,
  output logic [IW-1:0]   o_winner
);

  int unsigned w_idx;
  logic [IW-1:0] w_sel;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = i_ptr;
    w_idx    = 0;
    w_sel    = '0;
    // Walk from farthest to nearest so the nearest requester after i_ptr wins.
    for (int unsigned k = NDEV; k >= 1; k--) begin
      w_idx = (32'(i_ptr) + k) % NDEV;
      w_sel = IW'(w_idx);
      if (i_req[w_sel] && !(i_excl && (k == NDEV))) begin
        o_valid  = 1'b1;
        o_winner = w_sel;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grants with one-cycle turnaround gaps,
// bus parking on a default device and a grant timeout when FRAME never starts.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter  int unsigned NDEV    = 4,
  parameter  int unsigned PARK    = 0,
  parameter  int unsigned TIMEOUT = 16,
  localparam int unsigned IW      = IDX_W(NDEV)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NDEV-1:0] req,
  input  logic            frame,
  input  logic            irdy,
  output logic [NDEV-1:0] gnt,
  output logic [IW-1:0]   owner,
  output logic            bus_idle
);

  localparam int unsigned   TW          = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] PARK_IDX    = IW'(PARK);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);

  logic [1:0]      r_state,   w_state_d;
  logic [IW-1:0]   r_target,  w_target_d;
  logic            r_to_park, w_to_park_d;
  logic [IW-1:0]   r_owner,   w_owner_d;
  logic [IW-1:0]   r_ptr,     w_ptr_d;
  logic [TW-1:0]   r_timer,   w_timer_d;
  logic [NDEV-1:0] r_gnt,     w_gnt_d;
  logic            r_bus_idle;

  logic [NDEV-1:0] w_req_act;
  logic            w_excl;
  logic            w_valid;
  logic [IW-1:0]   w_winner;
  logic [TW-1:0]   w_timer_inc;

  assign w_req_act   = ~req;
  assign w_excl      = (r_state == ST_GRANTED);
  assign w_timer_inc = r_timer + 1'b1;

  rr_pick #(
    .NDEV(NDEV)
  ) u_rr_pick (
    .i_req    (w_req_act),
    .i_ptr    (r_ptr),
    .i_excl   (w_excl),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  always_comb begin
    w_state_d   = r_state;
    w_target_d  = r_target;
    w_to_park_d = r_to_park;
    w_owner_d   = r_owner;
    w_ptr_d     = r_ptr;
    w_timer_d   = '0;
    case (r_state)
      ST_PARK: begin
        w_owner_d = PARK_IDX;
        if (w_valid && (w_winner == PARK_IDX)) begin
          w_state_d = ST_GRANTED;
          w_ptr_d   = PARK_IDX;
        end else if (w_valid) begin
          w_state_d   = ST_TURN;
          w_target_d  = w_winner;
          w_to_park_d = 1'b0;
        end
      end
      ST_TURN: begin
        if (r_to_park) begin
          w_state_d = ST_PARK;
          w_owner_d = PARK_IDX;
        end else begin
          w_state_d = ST_GRANTED;
          w_owner_d = r_target;
          w_ptr_d   = r_target;
        end
      end
      ST_GRANTED: begin
        if (frame == ASSERTED) begin
          w_state_d = ST_BUSY;
        end else if (req[r_owner] == DEASSERTED || (w_timer_inc == TIMEOUT_VAL)) begin
          if (w_valid) begin
            w_state_d   = ST_TURN;
            w_target_d  = w_winner;
            w_to_park_d = 1'b0;
          end else if (req[r_owner] == ASSERTED) begin
            // Timeout with nobody else waiting: keep the grant, restart the count.
            w_timer_d = '0;
          end else if (r_owner == PARK_IDX) begin
            w_state_d = ST_PARK;
          end else begin
            w_state_d   = ST_TURN;
            w_to_park_d = 1'b1;
          end
        end else begin
          w_timer_d = w_timer_inc;
        end
      end
      default: begin
        if (frame == DEASSERTED && irdy == DEASSERTED) begin
          if (w_valid && (w_winner == r_owner)) begin
            w_state_d = ST_GRANTED;
          end else if (w_valid) begin
            w_state_d   = ST_TURN;
            w_target_d  = w_winner;
            w_to_park_d = 1'b0;
          end else if (r_owner == PARK_IDX) begin
            w_state_d = ST_PARK;
          end else begin
            w_state_d   = ST_TURN;
            w_to_park_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_gnt_d = '1;
    if (w_state_d != ST_TURN) begin
      w_gnt_d[w_owner_d] = ASSERTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_TURN;
      r_target   <= PARK_IDX;
      r_to_park  <= 1'b1;
      r_owner    <= PARK_IDX;
      r_ptr      <= PARK_IDX;
      r_timer    <= '0;
      r_gnt      <= '1;
      r_bus_idle <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_target   <= w_target_d;
      r_to_park  <= w_to_park_d;
      r_owner    <= w_owner_d;
      r_ptr      <= w_ptr_d;
      r_timer    <= w_timer_d;
      r_gnt      <= w_gnt_d;
      r_bus_idle <= frame & irdy;
    end
  end

  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign bus_idle = r_bus_idle;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: directed vector table, timeout and reset
// sequences, then random traffic against a behavioural arbitration model.
module tb_pci_arbiter;

  localparam int NDEV    = 4;
  localparam int PARK    = 0;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'hF;
  logic       frame = 1'b1;
  logic       irdy = 1'b1;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       bus_idle;

  pci_arbiter #(
    .NDEV    (NDEV),
    .PARK    (PARK),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .frame    (frame),
    .irdy     (irdy),
    .gnt      (gnt),
    .owner    (owner),
    .bus_idle (bus_idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the bus, and what happens next, in plain terms.
  typedef enum int {MParked, MGap, MHeld, MXfer} mmode_t;
  mmode_t m_mode;
  int     m_own;
  int     m_next;   // gap destination, -1 means return to park
  int     m_last;   // last device granted through arbitration
  int     m_age;
  int     m_idle;

  function automatic int rr(input logic [3:0] want, input int from, input bit skip_from);
    for (int k = 1; k <= NDEV; k++) begin
      int d;
      d = (from + k) % NDEV;
      if (!(skip_from && d == from) && want[d]) return d;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = MGap; m_next = -1; m_own = PARK; m_last = PARK; m_age = 0; m_idle = 1;
  endtask

  task automatic model_release();
    if (m_own == PARK) m_mode = MParked;
    else begin m_mode = MGap; m_next = -1; end
  endtask

  task automatic model_step(input logic [3:0] r, input logic f, input logic i);
    logic [3:0] want;
    int w;
    want = ~r;
    case (m_mode)
      MParked: begin
        w = rr(want, m_last, 1'b0);
        if (w == PARK) begin m_mode = MHeld; m_last = PARK; m_age = 0; end
        else if (w >= 0) begin m_mode = MGap; m_next = w; end
      end
      MGap: begin
        if (m_next < 0) begin m_mode = MParked; m_own = PARK; end
        else begin m_mode = MHeld; m_own = m_next; m_last = m_next; m_age = 0; end
      end
      MHeld: begin
        if (!f) m_mode = MXfer;
        else if (!want[m_own]) begin
          w = rr(want, m_last, 1'b1);
          if (w >= 0) begin m_mode = MGap; m_next = w; end
          else model_release();
        end else if (m_age + 1 >= TIMEOUT) begin
          w = rr(want, m_last, 1'b1);
          if (w >= 0) begin m_mode = MGap; m_next = w; end
          else m_age = 0;
        end else m_age++;
      end
      default: begin
        if (f && i) begin
          w = rr(want, m_last, 1'b0);
          if (w == m_own) begin m_mode = MHeld; m_age = 0; end
          else if (w >= 0) begin m_mode = MGap; m_next = w; end
          else model_release();
        end
      end
    endcase
    m_idle = int'(f & i);
  endtask

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    g = 4'hF;
    if (m_mode != MGap) g[m_own] = 1'b0;
    return g;
  endfunction

  task automatic step(input logic [3:0] r, input logic f, input logic i, input string tag);
    logic [3:0] prev;
    logic [3:0] rose;
    logic [3:0] fell;
    prev = gnt;
    req = r; frame = f; irdy = i;
    @(posedge clk);
    #1;
    model_step(r, f, i);
    rose = gnt & ~prev;
    fell = ~gnt & prev;
    chk({tag, " gnt"}, int'(gnt), int'(exp_gnt()));
    chk({tag, " owner"}, int'(owner), m_own);
    chk({tag, " bus_idle"}, int'(bus_idle), m_idle);
    chk({tag, " one grant"}, int'($countones(~gnt) <= 1), 1);
    chk({tag, " no overlap handoff"}, int'(rose != 0 && fell != 0), 0);
  endtask

  typedef struct {
    logic [3:0] r;
    logic       f;
    logic       i;
    logic [3:0] eg;
    int         eo;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] rr_req;
  logic rf, ri;

  initial begin
    // Fairness (req1+req3), back-to-back (req2), single transaction, parked device.
    tbl.push_back('{4'b0101, 1, 1, 4'hF, 0});
    tbl.push_back('{4'b0101, 1, 1, 4'hD, 1});
    tbl.push_back('{4'b0101, 0, 0, 4'hD, 1});
    tbl.push_back('{4'b0101, 1, 1, 4'hF, 1});
    tbl.push_back('{4'b0101, 1, 1, 4'h7, 3});
    tbl.push_back('{4'b0101, 0, 0, 4'h7, 3});
    tbl.push_back('{4'b0101, 1, 1, 4'hF, 3});
    tbl.push_back('{4'b0101, 1, 1, 4'hD, 1});
    tbl.push_back('{4'b0101, 0, 0, 4'hD, 1});
    tbl.push_back('{4'b0101, 1, 1, 4'hF, 1});
    tbl.push_back('{4'b0101, 1, 1, 4'h7, 3});
    tbl.push_back('{4'b1111, 1, 1, 4'hF, 3});
    tbl.push_back('{4'b1111, 1, 1, 4'hE, 0});
    tbl.push_back('{4'b1011, 1, 1, 4'hF, 0});
    tbl.push_back('{4'b1011, 1, 1, 4'hB, 2});
    tbl.push_back('{4'b1011, 0, 0, 4'hB, 2});
    tbl.push_back('{4'b1011, 1, 1, 4'hB, 2});
    tbl.push_back('{4'b1011, 0, 1, 4'hB, 2});
    tbl.push_back('{4'b1011, 1, 1, 4'hB, 2});
    tbl.push_back('{4'b1111, 1, 1, 4'hF, 2});
    tbl.push_back('{4'b1111, 1, 1, 4'hE, 0});
    tbl.push_back('{4'b1011, 1, 1, 4'hF, 0});
    tbl.push_back('{4'b1011, 1, 1, 4'hB, 2});
    tbl.push_back('{4'b1011, 0, 0, 4'hB, 2});
    tbl.push_back('{4'b1111, 0, 0, 4'hB, 2});
    tbl.push_back('{4'b1111, 1, 1, 4'hF, 2});
    tbl.push_back('{4'b1111, 1, 1, 4'hE, 0});
    tbl.push_back('{4'b1110, 1, 1, 4'hE, 0});
    tbl.push_back('{4'b1110, 1, 1, 4'hE, 0});
    tbl.push_back('{4'b1111, 1, 1, 4'hE, 0});

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gnt", int'(gnt), 'hF);
    chk("reset owner", int'(owner), 0);
    chk("reset bus_idle", int'(bus_idle), 1);
    rst_n = 1'b1;
    #1;
    chk("post-reset gap", int'(gnt), 'hF);
    step(4'hF, 1, 1, "park");
    chk("first park gnt", int'(gnt), 'hE);
    step(4'hF, 1, 1, "park hold");

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].r, tbl[k].f, tbl[k].i, "vec");
      chk($sformatf("vec%0d gnt", k), int'(gnt), int'(tbl[k].eg));
      chk($sformatf("vec%0d owner", k), int'(owner), tbl[k].eo);
    end

    // Timeout with another requester pending: 16 granted cycles, gap, then device 1.
    step(4'b0111, 1, 1, "to grant3");
    step(4'b0111, 1, 1, "to grant3");
    chk("to granted3", int'(gnt), 'h7);
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      step(4'b0101, 1, 1, "to hold");
      chk("to hold gnt", int'(gnt), 'h7);
    end
    step(4'b0101, 1, 1, "to revoke");
    chk("to revoke gnt", int'(gnt), 'hF);
    step(4'b0101, 1, 1, "to next");
    chk("to next gnt", int'(gnt), 'hD);

    // Timeout with nobody else waiting: grant held and the count restarts.
    step(4'b0111, 1, 1, "to2 gap");
    step(4'b0111, 1, 1, "to2 grant3");
    chk("to2 granted3", int'(gnt), 'h7);
    for (int k = 0; k < TIMEOUT; k++) step(4'b0111, 1, 1, "to2 hold");
    chk("to2 kept gnt", int'(gnt), 'h7);
    for (int k = 0; k < TIMEOUT - 2; k++) step(4'b0111, 1, 1, "to2 recount");
    step(4'b0101, 1, 1, "to2 late");
    chk("to2 not early", int'(gnt), 'h7);
    step(4'b0101, 1, 1, "to2 revoke");
    chk("to2 revoke gnt", int'(gnt), 'hF);
    step(4'b0101, 1, 1, "to2 next");

    // Asynchronous reset while device 1 owns a busy bus.
    step(4'b1101, 0, 0, "rb busy");
    step(4'b1101, 0, 1, "rb busy");
    chk("rb busy gnt", int'(gnt), 'hD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb async gnt", int'(gnt), 'hF);
    chk("rb async owner", int'(owner), 0);
    chk("rb async bus_idle", int'(bus_idle), 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rb gap", int'(gnt), 'hF);
    step(4'hF, 1, 1, "rb park");
    chk("rb park gnt", int'(gnt), 'hE);

    // Random traffic with slowly changing requests.
    rr_req = 4'hF;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(7) == 0) rr_req = 4'($urandom);
      rf = ($urandom_range(5) != 0);
      ri = ($urandom_range(3) != 0);
      step(rr_req, rf, ri, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
